// File: rtl/loop_track_scheduler.sv
// loop_track_scheduler: per-sample RAM sequencer for a two-track looper.
// Each tick reads track 0, reads track 1, optionally writes the live
// sample, then emits the saturated mix and advances the loop position.
// Ports:
//   clk, rst_n (sync, active-low)
//   sample_tick, rec_en, rec_track, clr, sig_in : control and live audio
//   mem_req/we/addr/wdata, mem_rdata, mem_ack  : RAM controller handshake
//   sig_out, sample_valid                      : mixed audio output
//   loop_len, overrun, busy                    : status
module loop_track_scheduler #(
  parameter int ADDR_W = 23,
  parameter int LEN_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  input  logic                     rec_en,
  input  logic                     rec_track,
  input  logic                     clr,
  input  logic signed [15:0]       sig_in,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_ack,
  output logic signed [15:0]       sig_out,
  output logic                     sample_valid,
  output logic [LEN_W-1:0]         loop_len,
  output logic                     overrun,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, WR, OUT
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t            state;
  logic [LEN_W-1:0]  pos;
  logic [LEN_W-1:0]  pos_inc;
  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  eff_pos;
  logic signed [15:0] cap_sig;
  logic signed [15:0] s0;
  logic signed [15:0] s1;
  logic              cap_rec;
  logic              cap_trk;
  logic              clr_pend;
  logic              play;

  assign busy    = (state != IDLE);
  assign play    = (loop_len != '0);
  assign pos_inc = pos + ONE;
  // A clr arriving with a tick in IDLE wins, so the tick sees define mode.
  assign eff_len = clr ? '0 : loop_len;
  assign eff_pos = clr ? '0 : pos;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic             trk,
    input logic [LEN_W-1:0] p
  );
    logic [ADDR_W-1:0] a;
    a = '0;
    a[LEN_W-1:0] = p;
    a[ADDR_W-1] = trk;
    return a;
  endfunction

  function automatic logic signed [15:0] sat16(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    logic signed [16:0] sum;
    sum = $signed({a[15], a}) + $signed({b[15], b});
    if (sum[16] != sum[15])
      return sum[16] ? 16'sh8000 : 16'sh7fff;
    return sum[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pos          <= '0;
      loop_len     <= '0;
      cap_sig      <= '0;
      cap_rec      <= 1'b0;
      cap_trk      <= 1'b0;
      s0           <= '0;
      s1           <= '0;
      clr_pend     <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      sig_out      <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && state != IDLE)
        overrun <= 1'b1;
      if (clr && state != IDLE)
        clr_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (clr) begin
            loop_len <= '0;
            pos      <= '0;
          end
          if (sample_tick) begin
            cap_sig <= sig_in;
            cap_rec <= rec_en;
            cap_trk <= rec_track;
            if (eff_len != '0) begin
              state <= RD0;
            end else if (rec_en) begin
              state <= WR;
            end else if (eff_pos != '0) begin
              // Closing the loop: play position 0 on this same tick.
              loop_len <= eff_pos;
              pos      <= '0;
              state    <= RD0;
            end else begin
              state <= OUT;
            end
          end
        end

        // Each access state raises its request one cycle after entry,
        // which guarantees an idle cycle between back-to-back accesses.
        RD0: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr_of(1'b0, pos);
          end else if (mem_ack) begin
            s0      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= RD1;
          end
        end

        RD1: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr_of(1'b1, pos);
          end else if (mem_ack) begin
            s1      <= mem_rdata;
            mem_req <= 1'b0;
            if (cap_rec) begin
              state <= WR;
            end else begin
              state        <= OUT;
              sample_valid <= 1'b1;
              sig_out      <= sat16(s0, mem_rdata);
            end
          end
        end

        WR: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr_of(cap_trk, pos);
            mem_wdata <= cap_sig;
          end else if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            state        <= OUT;
            sample_valid <= 1'b1;
            sig_out      <= play ? sat16(s0, s1) : cap_sig;
          end
        end

        OUT: begin
          if (!sample_valid) begin
            // Entered without any access: emit the monitor sample now.
            sample_valid <= 1'b1;
            sig_out      <= cap_sig;
          end else begin
            state    <= IDLE;
            clr_pend <= 1'b0;
            if (clr || clr_pend) begin
              loop_len <= '0;
              pos      <= '0;
            end else if (play) begin
              pos <= (pos == loop_len - ONE) ? '0 : pos_inc;
            end else if (cap_rec) begin
              if (pos_inc == LEN_MAX) begin
                loop_len <= LEN_MAX;
                pos      <= '0;
              end else begin
                pos <= pos_inc;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/loop_track_scheduler.md
Name: loop_track_scheduler

Overview:
- Sequences all audio-rate traffic to the external cellular-RAM controller for a two-track loop recorder/overdubber.
- On every sample tick it reads track 0, reads track 1, optionally writes the live signal into the selected track, then emits the saturated mix.
- Sits between the signal adder output (sig_in), the RAM controller's req/ack port, and the PMOD audio output.
- Owns loop position and loop length.

Parameters:
- ADDR_W, 23: RAM word-address width.
- LEN_W, 20: position/loop-length width. Maximum loop is 2^LEN_W-1 samples; LEN_W <= ADDR_W-1.

Ports:
- clk  in  1  100 MHz system clock
- rst_n  in  1  reset, synchronous, active-low
- sample_tick  in  1  one-cycle pulse per audio sample
- rec_en  in  1  record request; sampled only on sample_tick
- rec_track  in  1  track written when recording; sampled on sample_tick
- clr  in  1  one-cycle pulse: discard loop
- sig_in  in  16  signed live sample; captured on sample_tick
- mem_req  out  1  access request; held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse
- sig_out  out  16  signed mixed sample
- sample_valid  out  1  one-cycle pulse when sig_out updates
- loop_len  out  LEN_W  current loop length; 0 = undefined
- overrun  out  1  sticky: tick arrived while busy
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, pos=0, FSM=IDLE; takes effect mid-access too. mem_req drops the next cycle and any pending ack is ignored.
- Address: mem_addr = {track, zero padding, pos}. Track 1 base is 2^(ADDR_W-1); with the defaults, track 1 pos 0 = 0x400000.
- FSM states: IDLE, RD0, RD1, WR, OUT.
- IDLE, on sample_tick: capture sig_in, rec_en, rec_track.
  - Define mode (loop_len=0):
    - rec=1: go WR, writing sig_in at pos.
    - rec=0 and pos>0: set loop_len=pos, pos=0, go RD0 (playback of pos 0 this same tick).
    - rec=0 and pos=0: go OUT, no memory access.
  - Play mode (loop_len>0): go RD0.
- RD0 / RD1: mem_req=1, mem_we=0, track 0 / track 1 address at pos. Hold address until mem_ack; latch mem_rdata into s0 / s1.
  - RD1 exit: go WR if the captured rec is 1, else OUT.
- WR: mem_req=1, mem_we=1, mem_wdata=captured sig_in, address = captured rec_track at pos. Exit on mem_ack.
  - Writes always follow reads, so the same address reads its old data (replace-overdub).
- Request timing:
  - mem_req/we/addr/wdata are registered and stable while mem_req=1.
  - The cycle after mem_ack, mem_req=0.
  - The next request rises no earlier than the following cycle (≥1 idle cycle between accesses).
- OUT (one cycle), then IDLE. sample_valid=1 this cycle.
  - Define mode: sig_out = captured sig_in (monitor).
  - Play mode: sig_out = sat16(s0 + s1), with a 17-bit signed sum clamped to [-32768, 32767].
  - Position advance: play mode, pos = (pos == loop_len-1) ? 0 : pos+1. Define mode with rec=1, pos+1.
    - If pos+1 would reach 2^LEN_W-1, loop_len = 2^LEN_W-1 and pos = 0 (auto-close).
- Latency: sample_valid 1 cycle after the last mem_ack of the tick. With no access, 2 cycles after sample_tick.
- Overrun:
  - A sample_tick while busy=1 sets overrun (cleared only by reset).
  - The tick is dropped: no capture, pos not advanced.
  - A tick in the same cycle as the OUT→IDLE transition also counts as busy.
- clr:
  - Latched if busy; applied on entry to IDLE.
  - Sets loop_len=0 and pos=0; RAM contents untouched.
  - A clr coinciding with sample_tick in IDLE applies first; that tick is then processed in define mode.
- Inputs other than sample_tick and clr are ignored outside IDLE.

Test Plan:
- Define: reset; rec_en=1, rec_track=0; 4 ticks with sig_in 100,200,300,400 -> writes to addr 0..3 with those values, sig_out passthrough 100..400. 5th tick with rec_en=0 -> loop_len=4, reads of 0x000000 and 0x400000, sig_out=100.
- Wrap: continue ticks with rec_en=0, track-1 RAM=0 -> sig_out 200,300,400,100,200; read addresses pos cycle 1,2,3,0,1.
- Overdub: rec_track=1, sig_in=1000 for 4 ticks -> each tick RD0, RD1, WR at 0x400000+pos; first pass sig_out 100..400 (old track-1 data); next pass sig_out 1100,1200,1300,1400.
- Saturation: track0=30000, track1=10000 -> 32767; -30000 and -10000 -> -32768; 0x7FFF+0x8000 -> -1.
- Overrun/stall: memory model delays ack 50 cycles, second tick 10 cycles after the first -> overrun=1, pos advances by exactly 1, mem_req held with stable addr the whole stall.
- Reset/clr mid-access: rst_n=0 while mem_req=1 -> next cycle all outputs 0, a late ack ignored. clr during RD1 -> tick completes normally, then loop_len=0, pos=0.
